split_data: RTL
===============

# split_data

Read-path width converter for the VDMA. It takes wide OSIZE-bit words fetched from memory over a valid/ready stream and emits ISIZE-bit pixels, MSB-first, over a valid/ready stream. Residual bits carry across word boundaries when OSIZE is not a multiple of ISIZE. It sits between the read-data FIFO and the video output and mirrors the write-path pixel combiner.

## Interface
- ISIZE, 24, pixel width in bits; 1 ≤ ISIZE ≤ OSIZE
- OSIZE, 256, memory word width in bits
- clock  in  1  sole clock
- rst  in  1  reset; one clock, synchronous, active-high
- ialign  in  1  start-of-line flush; discards all buffered bits
- ivalid  in  1  input word valid
- iready  out  1  input word accepted when ivalid && iready
- idata  in  OSIZE  wide word; first pixel in idata[OSIZE-1 -: ISIZE]
- ilast  in  1  word is the last of the line; qualified by the input handshake
- ovalid  out  1  pixel valid
- oready  in  1  pixel consumed when ovalid && oready
- odata  out  ISIZE  pixel
- olast  out  1  last pixel of the line; qualified by ovalid

## Operation
- Buffer `buf` is BW = OSIZE+ISIZE-1 bits, MSB-aligned; `cnt` counts valid bits ($clog2(BW+1) wide).
- pop = ovalid && oready; push = ivalid && iready.
- ovalid = (cnt ≥ ISIZE); odata = buf[BW-1 -: ISIZE].
- iready = (state != TAIL) && (cnt < ISIZE || (cnt < 2*ISIZE && pop)). This is a combinational path from oready to iready and gives full throughput.
- On pop: buf shifts left by ISIZE and cnt -= ISIZE.
- On push: idata is written at buf[BW-1-cnt' -: OSIZE], where cnt' is cnt after any same-cycle pop. Then cnt = cnt' + OSIZE.
- FSM:
  - IDLE: cnt < ISIZE and no line data. Goes to RUN on push without ilast, or to TAIL on push with ilast.
  - RUN: streaming. Goes to TAIL on push with ilast.
  - TAIL: last word loaded; no further pushes are accepted. On the pop that leaves cnt < ISIZE, olast=1 on that pixel, the remaining residual (< ISIZE bits) is discarded, cnt=0, and the FSM goes to IDLE.
- olast = (state == TAIL) && (cnt < 2*ISIZE) && ovalid.
- ialign has priority over everything: cnt=0, state=IDLE, no push or pop takes effect in that cycle, and iready=0 in that cycle.
- A residual of fewer than ISIZE bits in IDLE/RUN is kept and joined with the next word.

## Timing
- Reset values: iready=0 during rst, 1 in the first cycle after; ovalid=0, olast=0, odata=0, cnt=0, state=IDLE.
- Latency: word accepted in cycle N → first pixel with ovalid=1 in cycle N+1. Add one cycle with the output register configured (see Configuration).
- Throughput: one pixel per cycle while the input supplies words and oready=1.
- odata/ovalid/olast are held stable while ovalid && !oready.
- A rst mid-line clears the buffer with no olast emitted. The next line starts clean.

## Configuration
- SPLIT_DATA_OREG_EN defined:
  - Adds an output pipeline register with a skid slot (2-entry).
  - odata/ovalid/olast are driven from flops.
  - Latency becomes N+2; throughput is unchanged.
  - ialign and rst also clear the register stage.
- SPLIT_DATA_OREG_EN undefined: outputs are driven directly from buf/cnt/state as described above.

## Structure
- The shared VDMA package holds:
  - the FSM state enum (IDLE, RUN, TAIL);
  - the BW function;
  - the $clog2-based cnt width function, reused by the write-path combiner.
- One sub-module, `split_data_oreg`, is the 2-entry skid register. It is instantiated only under SPLIT_DATA_OREG_EN.
- Elaboration check: error if ISIZE > OSIZE.

## Test plan
- ISIZE=24, OSIZE=256, three words pushed back-to-back, oready=1, third word ilast → 32 pixels on 32 consecutive cycles.
  - pixel0 = w0[255:232].
  - pixel10 = {w0[15:0], w1[255:248]}.
  - olast only on pixel31; cnt=0 afterwards.
- Single word with ilast → 10 pixels, olast on pixel9, 16 residual bits dropped, iready=0 throughout TAIL.
- oready toggled pseudo-randomly at 50% over a 5-word line → pixel sequence is identical to the oready=1 run, and outputs are stable while stalled.
- ialign pulsed with cnt=16 mid-line → next pixel comes entirely from the next pushed word's MSBs, with no stale bits.
- rst asserted while in TAIL with ovalid=1 → next cycle ovalid=0, olast=0, cnt=0; a fresh line decodes correctly.
- ISIZE=32, OSIZE=256 → 8 pixels per word, no residual, iready high on every 8th cycle with continuous flow. Repeat the full suite with SPLIT_DATA_OREG_EN defined and check the +1 latency.

Source files
------------

// File: rtl/split_data_pkg.sv
// Shared VDMA definitions for the read-path splitter and the write-path combiner.
package split_data_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } splitState_t;

  // The buffer must hold one full word on top of a residual of at most ISIZE-1 bits.
  function automatic int calcBw(input int isize, input int osize);
    return osize + isize - 1;
  endfunction

  function automatic int calcCntWidth(input int bw);
    return $clog2(bw + 1);
  endfunction

endpackage

// File: rtl/split_data_if.sv
// Valid/ready stream bundle with an end-of-line marker, used on both sides of split_data.
interface split_data_if #(
  parameter int W = 24
) ();

  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/split_data_oreg.sv
// Two-entry skid register that retimes the pixel stream; its ready is a flop, not a path from downstream.
module split_data_oreg #(
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_last
);

  logic [W-1:0] r_data0;
  logic [W-1:0] r_data1;
  logic         r_last0;
  logic         r_last1;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data0;
  assign o_last  = r_last0 && o_valid;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clock) begin
    if (rst || i_clear) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end else begin
            r_data1 <= i_data;
            r_last1 <= i_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new pixel arrives; occupancy is unchanged.
          if (r_count == 2'd1) begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= i_data;
            r_last1 <= i_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/split_data.sv
// Read-path width converter: OSIZE-bit memory words in, ISIZE-bit pixels out, MSB first.
// Define SPLIT_DATA_OREG_EN to register the pixel outputs through split_data_oreg (+1 cycle latency).
module split_data
  import split_data_pkg::*;
#(
  parameter int ISIZE = 24,
  parameter int OSIZE = 256
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          ialign,
  split_data_if.slave   i_word,
  split_data_if.master  o_pix
);

  localparam int BW = calcBw(ISIZE, OSIZE);
  localparam int CW = calcCntWidth(BW);
  localparam logic [CW-1:0] ISZ = CW'(ISIZE);
  localparam logic [CW-1:0] OSZ = CW'(OSIZE);

  if (ISIZE > OSIZE || ISIZE < 1) begin : g_cfgCheck
    $error("split_data: ISIZE must lie in 1..OSIZE");
  end

  splitState_t      r_state;
  splitState_t      w_stateNext;
  logic [BW-1:0]    r_buf;
  logic [BW-1:0]    w_bufNext;
  logic [BW-1:0]    w_bufShift;
  logic [BW-1:0]    w_wordAligned;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cntNext;
  logic [CW-1:0]    w_cntShift;
  logic             w_ovalid;
  logic             w_olast;
  logic             w_oready;
  logic             w_iready;
  logic             w_pop;
  logic             w_push;
  logic [ISIZE-1:0] w_odata;

  assign w_ovalid = (int'(r_cnt) >= ISIZE);
  assign w_odata  = r_buf[BW-1 -: ISIZE];
  assign w_olast  = (r_state == TAIL) && (int'(r_cnt) < 2 * ISIZE) && w_ovalid;
  assign w_pop    = w_ovalid && w_oready;

  // Accept a word only once the residual left after this cycle's pop is below one pixel.
  assign w_iready = !rst && !ialign && (r_state != TAIL) &&
                    ((int'(r_cnt) < ISIZE) || ((int'(r_cnt) < 2 * ISIZE) && w_pop));
  assign w_push   = i_word.valid && w_iready;
  assign i_word.ready = w_iready;

  assign w_wordAligned = BW'(i_word.data) << (BW - OSIZE);

  always_comb begin
    w_bufShift  = w_pop ? (r_buf << ISIZE) : r_buf;
    w_cntShift  = w_pop ? (r_cnt - ISZ) : r_cnt;
    w_bufNext   = w_bufShift;
    w_cntNext   = w_cntShift;
    w_stateNext = r_state;
    if (ialign) begin
      w_bufNext   = '0;
      w_cntNext   = '0;
      w_stateNext = IDLE;
    end else if (w_push) begin
      // Bits below the valid region are always zero, so the new word can simply be ORed in.
      w_bufNext   = w_bufShift | (w_wordAligned >> w_cntShift);
      w_cntNext   = w_cntShift + OSZ;
      w_stateNext = i_word.last ? TAIL : RUN;
    end else if ((r_state == TAIL) && w_pop && (int'(w_cntShift) < ISIZE)) begin
      w_bufNext   = '0;
      w_cntNext   = '0;
      w_stateNext = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_buf   <= w_bufNext;
      r_cnt   <= w_cntNext;
    end
  end

`ifdef SPLIT_DATA_OREG_EN
  logic             w_regValid;
  logic             w_regLast;
  logic [ISIZE-1:0] w_regData;

  split_data_oreg #(
    .W(ISIZE)
  ) u_oreg (
    .clock   (clock),
    .rst     (rst),
    .i_clear (ialign),
    .i_valid (w_ovalid),
    .o_ready (w_oready),
    .i_data  (w_odata),
    .i_last  (w_olast),
    .o_valid (w_regValid),
    .i_ready (o_pix.ready),
    .o_data  (w_regData),
    .o_last  (w_regLast)
  );

  assign o_pix.valid = w_regValid;
  assign o_pix.data  = w_regData;
  assign o_pix.last  = w_regLast;
`else
  assign w_oready    = o_pix.ready;
  assign o_pix.valid = w_ovalid;
  assign o_pix.data  = w_odata;
  assign o_pix.last  = w_olast;
`endif

endmodule
